uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver: 8 data bits, LSB first, one start bit, one stop bit, no parity. It is the receive-side companion of the existing transmitter (uart_tx) and uses the same CLKS_PER_BIT convention. It oversamples the line with the system clock, samples each bit at its centre, and delivers each byte with a one-cycle valid strobe. It also flags framing errors and rejects start-bit glitches.

Parameters:
CLKS_PER_BIT, 347, clock cycles per UART bit = f(i_Clock)/baud; legal range 4..65535 (16-bit counter).

Ports:
i_Clock  input  1  system clock; all logic on rising edge.
i_Rst_n  input  1  asynchronous active-low reset.
i_Rx_Serial  input  1  asynchronous serial line; idle high.
o_Rx_DV  output  1  one-cycle pulse: o_Rx_Byte holds a newly received valid byte.
o_Rx_Byte  output  8  last valid received byte; held until the next valid byte.
o_Rx_Active  output  1  high while a frame is in progress (START through STOP).
o_Rx_Frame_Err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset (async assert, sync release): state IDLE; o_Rx_DV=0, o_Rx_Byte=8'h00, o_Rx_Active=0, o_Rx_Frame_Err=0; counters and shift register cleared; both synchronizer flops reset to 1.
- Synchronizer: two flops on i_Rx_Serial. "rx_s" denotes the second flop output. All decisions use rx_s, so there are 2 cycles of input latency.
- Bit counter: 16 bits. Data bit index: 3 bits.
- HALF = (CLKS_PER_BIT-1)/2, integer division.
- IDLE: clear the clock counter and bit index. If rx_s==0: go to START and set o_Rx_Active=1.
- START: count to HALF.
  - At HALF, if rx_s==0: clear counter, go to DATA.
  - At HALF, if rx_s==1: treat as a glitch. Return to IDLE with o_Rx_Active=0; no strobes.
- DATA: count to CLKS_PER_BIT-1, then sample rx_s into bit[index] and clear the counter.
  - Index 0..6: increment the index.
  - Index 7: go to STOP.
- STOP: count to CLKS_PER_BIT-1, then sample rx_s.
  - rx_s==1: load o_Rx_Byte from the shift register, pulse o_Rx_DV for the next cycle, go to CLEANUP.
  - rx_s==0: pulse o_Rx_Frame_Err for the next cycle, leave o_Rx_Byte unchanged, go to BREAK_WAIT.
  - In both cases o_Rx_Active drops at the same edge.
- CLEANUP: one cycle. o_Rx_DV is high during it; it is then deasserted. Go to IDLE.
- BREAK_WAIT: o_Rx_Frame_Err is high for the first cycle only. Stay until rx_s==1, then go to IDLE. This prevents a break or held-low line from re-triggering a start.
- Sampling points relative to the first cycle rx_s is seen low in IDLE:
  - start check at +1+HALF;
  - data bit k at +1+HALF+(k+1)*CLKS_PER_BIT;
  - stop bit at +1+HALF+9*CLKS_PER_BIT.
  - o_Rx_DV or o_Rx_Frame_Err is high in the following cycle.
- o_Rx_DV and o_Rx_Frame_Err are never high together, and each is never high for more than 1 cycle per frame.
- Back-to-back frames: a start edge arriving while in CLEANUP is picked up on the IDLE cycle that follows. This adds at most 1 cycle of slip, which is well within tolerance for CLKS_PER_BIT≥4.
- Illegal or unused state encodings return to IDLE on the next clock.
- Reset mid-frame: immediate return to reset values. A partial byte is never emitted.

Test Plan:
1. Loopback against uart_tx, CLKS_PER_BIT=8: send 8'hA5 -> exactly one o_Rx_DV pulse with o_Rx_Byte=8'hA5; o_Rx_Frame_Err stays 0. Repeat for 8'h00, 8'hFF and 8'h01 to cover LSB-first ordering.
2. Timing, CLKS_PER_BIT=347, byte 8'h3C -> o_Rx_DV rises exactly 1+173+9*347+1 cycles after rx_s first goes low. o_Rx_Active is high from the cycle after detection until the stop sample.
3. Glitch: drive i_Rx_Serial low for 2 cycles (CLKS_PER_BIT=8), then high -> no o_Rx_DV, no o_Rx_Frame_Err, state back in IDLE, o_Rx_Byte unchanged.
4. Framing error: send 8'h55 with the stop bit forced low, then hold the line low for 40 cycles before releasing -> one o_Rx_Frame_Err pulse, no o_Rx_DV, o_Rx_Byte keeps its prior value. A following valid 8'hC3 is received correctly.
5. Back-to-back: uart_tx streams 8'h12, 8'h34, 8'h56 with no gap -> three o_Rx_DV pulses with bytes in order.
6. Reset: assert i_Rst_n low after data bit 3 of 8'h9A, release, then send 8'h7E -> no output for the aborted frame, all outputs at reset values, then o_Rx_Byte=8'h7E.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with centre sampling, glitch rejection and framing-error detection.
module uart_rx #(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
);
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP, BREAK_WAIT} state_t;
  state_t state, state_d;
  logic rx_m, rx_s;
  logic [15:0] cnt, cnt_d;
  logic [2:0] idx, idx_d;
  logic [7:0] shift, shift_d, byte_d;
  logic dv_d, fe_d, act_d;
  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      o_Rx_Byte <= '0;
      o_Rx_DV <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
      o_Rx_Active <= 1'b0;
    end else begin
      rx_m <= i_Rx_Serial;
      rx_s <= rx_m;
      state <= state_d;
      cnt <= cnt_d;
      idx <= idx_d;
      shift <= shift_d;
      o_Rx_Byte <= byte_d;
      o_Rx_DV <= dv_d;
      o_Rx_Frame_Err <= fe_d;
      o_Rx_Active <= act_d;
    end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    idx_d = idx;
    shift_d = shift;
    byte_d = o_Rx_Byte;
    dv_d = 1'b0;
    fe_d = 1'b0;
    act_d = o_Rx_Active;
    case (state)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) begin
          state_d = START;
          act_d = 1'b1;
        end
      end
      START:
        if (cnt == HALF) begin
          cnt_d = '0;
          state_d = rx_s ? IDLE : DATA;
          act_d = !rx_s;
        end else cnt_d = cnt + 16'd1;
      DATA:
        if (cnt == LAST) begin
          cnt_d = '0;
          shift_d[idx] = rx_s;
          idx_d = idx + 3'd1;
          if (idx == 3'd7) state_d = STOP;
        end else cnt_d = cnt + 16'd1;
      STOP:
        if (cnt == LAST) begin
          cnt_d = '0;
          act_d = 1'b0;
          dv_d = rx_s;
          fe_d = !rx_s;
          byte_d = rx_s ? shift : o_Rx_Byte;
          state_d = rx_s ? CLEANUP : BREAK_WAIT;
        end else cnt_d = cnt + 16'd1;
      CLEANUP: state_d = IDLE;
      BREAK_WAIT: state_d = rx_s ? IDLE : BREAK_WAIT;
      default: begin
        state_d = IDLE;
        act_d = 1'b0;
      end
    endcase
  end
endmodule
